// File: rtl/bin_cnt_pkg.sv
// Shared constants and helpers for the binary up/down counter.
package bin_cnt_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // All-ones pattern for a given width (valid for widths up to 64).
    function automatic logic [63:0] all_ones(input int unsigned width);
        logic [63:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/bin_step_adder.sv
// Combinational add/subtract of two unsigned operands with carry/borrow reporting.
module bin_step_adder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] result_o,
    output logic             evt_o
);

    logic [WIDTH:0] ext;

    // Extra MSB is the carry on add and goes high on borrow (b > a) on subtract.
    always_comb begin
        if (sub_i) begin
            ext = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            ext = {1'b0, a_i} + {1'b0, b_i};
        end
    end

    assign result_o = ext[WIDTH-1:0];
    assign evt_o    = ext[WIDTH];

endmodule

// File: rtl/bin_updown_counter.sv
// Synchronous up/down counter with step, load, wrap/saturate and carry/borrow flag.
// Define CNT_OVF_STICKY_EN to add the sticky overflow flag (ovf_clr / ovf_sticky).
module bin_updown_counter
    import bin_cnt_pkg::*;
#(
    parameter int unsigned      WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] step,
    input  logic             sat_mode,
`ifdef CNT_OVF_STICKY_EN
    input  logic             ovf_clr,
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] count,
    output logic             cout,
    output logic             tc
);

    localparam logic [63:0]      AllOnes64 = all_ones(WIDTH);
    localparam logic [WIDTH-1:0] MaxVal    = AllOnes64[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             cout_q, cout_d;
    logic [WIDTH-1:0] add_res;
    logic             add_evt;
    logic             cnt_evt;

    bin_step_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i      (count_q),
        .b_i      (step),
        .sub_i    (up_dn == DIR_DOWN),
        .result_o (add_res),
        .evt_o    (add_evt)
    );

    // An event only counts on an edge that actually performs a count.
    assign cnt_evt = en && !load && add_evt;

    always_comb begin
        count_d = count_q;
        cout_d  = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            cout_d = add_evt;
            if (add_evt && (sat_mode == MODE_SAT)) begin
                count_d = (up_dn == DIR_UP) ? MaxVal : '0;
            end else begin
                count_d = add_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
            cout_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            cout_q  <= cout_d;
        end
    end

`ifdef CNT_OVF_STICKY_EN
    logic ovf_q, ovf_d;

    // Set wins over clear when both happen on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (cnt_evt) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_sticky = ovf_q;
`else
    logic unused_evt;
    assign unused_evt = cnt_evt;
`endif

    assign count = count_q;
    assign cout  = cout_q;
    assign tc    = (up_dn == DIR_UP) ? (count_q == MaxVal) : (count_q == '0);

endmodule

// File: tb/tb_bin_updown_counter.sv
// Self-checking bench for bin_updown_counter (WIDTH=4, RST_VAL=0): vector table,
// hand-written corner sequences and randomized stimulus against an arithmetic model.
module tb_bin_updown_counter;

    localparam int unsigned WIDTH = 4;
    localparam int          MAXV  = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       up_dn = 1'b1;
    logic [3:0] step = '0;
    logic       sat_mode = 1'b0;
    logic       ovf_clr_drv = 1'b0;
    logic [3:0] count;
    logic       cout;
    logic       tc;
`ifdef CNT_OVF_STICKY_EN
    logic       ovf_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_count  = 0;
    int m_cout   = 0;
    int m_sticky = 0;

    bin_updown_counter #(
        .WIDTH   (WIDTH),
        .RST_VAL (4'd0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .load_val   (load_val),
        .up_dn      (up_dn),
        .step       (step),
        .sat_mode   (sat_mode),
`ifdef CNT_OVF_STICKY_EN
        .ovf_clr    (ovf_clr_drv),
        .ovf_sticky (ovf_sticky),
`endif
        .count      (count),
        .cout       (cout),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       e;
        logic       l;
        logic [3:0] lv;
        logic       u;
        logic [3:0] s;
        logic       sm;
        int         exp_cnt;
        logic       exp_cout;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, e, l, input logic [3:0] lv, input logic u,
                                input logic [3:0] s, input logic sm, input int ec,
                                input logic eco, input logic etc);
        vec_t v;
        v = '{r, e, l, lv, u, s, sm, ec, eco, etc};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next-state model from plain integer arithmetic, evaluated just before the edge.
    task automatic model_step();
        int nxt;
        bit evt;
        evt = 1'b0;
        if (!rst_n) begin
            m_count  = 0;
            m_cout   = 0;
            m_sticky = 0;
        end else begin
            if (load) begin
                m_count = int'(load_val);
                m_cout  = 0;
            end else if (en) begin
                nxt = up_dn ? m_count + int'(step) : m_count - int'(step);
                evt = (nxt > MAXV) || (nxt < 0);
                if (evt && sat_mode) nxt = up_dn ? MAXV : 0;
                m_count = (nxt + 16) % 16;
                m_cout  = evt ? 1 : 0;
            end else begin
                m_cout = 0;
            end
            if (evt) m_sticky = 1;
            else if (ovf_clr_drv) m_sticky = 0;
        end
    endtask

    task automatic drive(input logic r, e, l, input logic [3:0] lv, input logic u,
                         input logic [3:0] s, input logic sm, input logic clr);
        rst_n       = r;
        en          = e;
        load        = l;
        load_val    = lv;
        up_dn       = u;
        step        = s;
        sat_mode    = sm;
        ovf_clr_drv = clr;
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst, en, load, load_val, up, step, sat -> count, cout, tc
        add(0, 0, 0,  0, 1, 0, 0,  0, 0, 0);
        add(1, 0, 1,  9, 1, 0, 0,  9, 0, 0);
        add(0, 1, 1,  5, 1, 1, 0,  0, 0, 0);  // reset beats load and en
        add(0, 1, 0,  0, 1, 1, 0,  0, 0, 0);
        add(1, 0, 1, 14, 1, 1, 0, 14, 0, 0);
        add(1, 1, 0,  0, 1, 1, 0, 15, 0, 1);
        add(1, 1, 0,  0, 1, 1, 0,  0, 1, 0);  // wrap 15 -> 0
        add(1, 1, 0,  0, 1, 1, 0,  1, 0, 0);
        add(1, 0, 1, 13, 1, 2, 1, 13, 0, 0);
        add(1, 1, 0,  0, 1, 2, 1, 15, 0, 1);
        add(1, 1, 0,  0, 1, 2, 1, 15, 1, 1);  // saturate
        add(1, 1, 0,  0, 1, 2, 1, 15, 1, 1);
        add(1, 1, 0,  0, 1, 0, 1, 15, 0, 1);  // step 0 clears cout
        add(1, 0, 1,  1, 0, 3, 0,  1, 0, 0);
        add(1, 1, 0,  0, 0, 3, 0, 14, 1, 0);  // borrow wrap
        add(1, 0, 1,  1, 0, 3, 1,  1, 0, 0);
        add(1, 1, 0,  0, 0, 3, 1,  0, 1, 1);  // borrow saturate
        add(1, 0, 0,  0, 0, 3, 1,  0, 0, 1);
        add(1, 0, 0,  0, 0, 3, 1,  0, 0, 1);
        add(1, 0, 0,  0, 0, 3, 1,  0, 0, 1);
        add(1, 1, 1,  9, 1, 3, 1,  9, 0, 0);  // load beats en

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].lv, vecs[i].u, vecs[i].s,
                  vecs[i].sm, 1'b0);
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].exp_cnt);
            chk($sformatf("vec%0d cout", i), int'(cout), int'(vecs[i].exp_cout));
            chk($sformatf("vec%0d tc", i), int'(tc), int'(vecs[i].exp_tc));
        end

        // tc follows up_dn combinationally with no clock edge
        drive(1, 0, 1, 15, 1, 0, 0, 0);
        @(negedge clk);
        up_dn = 1'b0;
        #1 chk("tc down at 15", int'(tc), 0);
        up_dn = 1'b1;
        #1 chk("tc up at 15", int'(tc), 1);

        // Reset mid-count, held for several edges
        drive(1, 1, 0, 0, 1, 1, 0, 0);
        chk("pre-reset count", int'(count), 0);
        drive(1, 1, 0, 0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 1, 3, 0, 0);
        chk("mid reset count", int'(count), 0);
        drive(0, 1, 1, 7, 1, 3, 0, 0);
        chk("held reset count", int'(count), 0);
        chk("held reset cout", int'(cout), 0);

`ifdef CNT_OVF_STICKY_EN
        chk("sticky after reset", int'(ovf_sticky), 0);
        drive(1, 0, 1, 15, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 1, 1, 0, 0);
        chk("sticky set", int'(ovf_sticky), 1);
        drive(1, 0, 1, 3, 1, 1, 0, 0);
        chk("sticky survives load", int'(ovf_sticky), 1);
        drive(1, 0, 0, 0, 1, 1, 0, 1);
        chk("sticky cleared", int'(ovf_sticky), 0);
        drive(1, 0, 1, 15, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 1, 1, 0, 1);
        chk("sticky set beats clr", int'(ovf_sticky), 1);
`endif

        // Randomized phase against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), 4'($urandom), 1'($urandom), 4'($urandom),
                  1'($urandom), ($urandom_range(0, 5) == 0));
            chk("rand count", int'(count), m_count);
            chk("rand cout", int'(cout), m_cout);
            chk("rand tc", int'(tc), up_dn ? int'(m_count == MAXV) : int'(m_count == 0));
`ifdef CNT_OVF_STICKY_EN
            chk("rand sticky", int'(ovf_sticky), m_sticky);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
